// File: rtl/dmem_arbiter_if.sv
// Bus bundle for dmem_arbiter: core port, loader port and memory side.
// The arbiter uses the slave modport; the environment uses master.
interface dmem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              c_req;
  logic              c_we;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata;
  logic              c_gnt;
  logic              c_rvalid;
  logic [DATA_W-1:0] c_rdata;
  logic              c_stall;

  logic              l_req;
  logic              l_we;
  logic [ADDR_W-1:0] l_addr;
  logic [DATA_W-1:0] l_wdata;
  logic              l_gnt;
  logic              l_rvalid;
  logic [DATA_W-1:0] l_rdata;
  logic              l_lock;

  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] m_rdata;

  modport slave (
    input  c_req, c_we, c_addr, c_wdata,
    output c_gnt, c_rvalid, c_rdata, c_stall,
    input  l_req, l_we, l_addr, l_wdata, l_lock,
    output l_gnt, l_rvalid, l_rdata,
    output m_we, m_addr, m_wdata,
    input  m_rdata
  );

  modport master (
    output c_req, c_we, c_addr, c_wdata,
    input  c_gnt, c_rvalid, c_rdata, c_stall,
    output l_req, l_we, l_addr, l_wdata, l_lock,
    input  l_gnt, l_rvalid, l_rdata,
    input  m_we, m_addr, m_wdata,
    output m_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the data memory between core and loader ports.
// Optional loader lock mode (LOCK state, forced core slot) enabled by DMEM_ARB_LOCK_EN.
module dmem_arbiter #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned LOCK_MAX = 8
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  bus
);

  typedef enum logic {ST_ARB, ST_LOCK} state_e;

  state_e            state_q, state_d;
  logic              last_q, last_d;      // 1: loader was granted last
  logic              c_gnt, l_gnt;
  logic              c_rvalid_q, c_rvalid_d;
  logic              l_rvalid_q, l_rvalid_d;
  logic [DATA_W-1:0] c_rdata_q, c_rdata_d;
  logic [DATA_W-1:0] l_rdata_q, l_rdata_d;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;

`ifdef DMEM_ARB_LOCK_EN
  localparam int unsigned CNT_W = $clog2(LOCK_MAX + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`else
  localparam int unsigned unused_lock_max = LOCK_MAX;
  logic unused_lock;
  assign unused_lock = bus.l_lock;
`endif

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    c_gnt   = 1'b0;
    l_gnt   = 1'b0;
`ifdef DMEM_ARB_LOCK_EN
    cnt_d   = cnt_q;
`endif
    if (rst) begin
      case (state_q)
        ST_ARB: begin
          if (bus.c_req && bus.l_req) begin
            c_gnt = last_q;
            l_gnt = ~last_q;
          end else begin
            c_gnt = bus.c_req;
            l_gnt = bus.l_req;
          end
`ifdef DMEM_ARB_LOCK_EN
          // The grant that opens the lock counts as the first locked loader cycle
          if (l_gnt && bus.l_lock) begin
            state_d = ST_LOCK;
            cnt_d   = CNT_W'(1);
          end
`endif
        end
        ST_LOCK: begin
`ifdef DMEM_ARB_LOCK_EN
          if (cnt_q == CNT_W'(LOCK_MAX) && bus.c_req) begin
            c_gnt = 1'b1;
            cnt_d = '0;
            if (!bus.l_lock) state_d = ST_ARB;
          end else if (bus.l_req) begin
            l_gnt = 1'b1;
            if (cnt_q != CNT_W'(LOCK_MAX)) cnt_d = cnt_q + CNT_W'(1);
            if (!bus.l_lock) begin
              state_d = ST_ARB;
              cnt_d   = '0;
            end
          end else begin
            state_d = ST_ARB;
            cnt_d   = '0;
          end
`else
          state_d = ST_ARB;
`endif
        end
      endcase
      if (c_gnt)      last_d = 1'b0;
      else if (l_gnt) last_d = 1'b1;
    end
  end

  always_comb begin
    m_we    = 1'b0;
    m_addr  = bus.c_addr;
    m_wdata = '0;
    if (c_gnt) begin
      m_we    = bus.c_we;
      m_wdata = bus.c_wdata;
    end else if (l_gnt) begin
      m_we    = bus.l_we;
      m_addr  = bus.l_addr;
      m_wdata = bus.l_wdata;
    end
    c_rvalid_d = c_gnt & ~bus.c_we;
    l_rvalid_d = l_gnt & ~bus.l_we;
    c_rdata_d  = c_rvalid_d ? bus.m_rdata : c_rdata_q;
    l_rdata_d  = l_rvalid_d ? bus.m_rdata : l_rdata_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_ARB;
      last_q     <= 1'b1;
      c_rvalid_q <= 1'b0;
      l_rvalid_q <= 1'b0;
      c_rdata_q  <= '0;
      l_rdata_q  <= '0;
`ifdef DMEM_ARB_LOCK_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      c_rvalid_q <= c_rvalid_d;
      l_rvalid_q <= l_rvalid_d;
      c_rdata_q  <= c_rdata_d;
      l_rdata_q  <= l_rdata_d;
`ifdef DMEM_ARB_LOCK_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  assign bus.c_gnt    = c_gnt;
  assign bus.l_gnt    = l_gnt;
  assign bus.c_stall  = bus.c_req & ~c_gnt;
  assign bus.c_rvalid = c_rvalid_q;
  assign bus.l_rvalid = l_rvalid_q;
  assign bus.c_rdata  = c_rdata_q;
  assign bus.l_rdata  = l_rdata_q;
  assign bus.m_we     = m_we;
  assign bus.m_addr   = m_addr;
  assign bus.m_wdata  = m_wdata;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-port data memory between the core's load/store path and a loader/DMA port. Sits between the core datapath and `d_memory`. Each cycle it grants at most one requester, drives the memory address, write-enable and write-data, and returns read data with a one-cycle registered response. Core stalls are derived from its grant.

## Interface
- `ADDR_W`, 32, address width of both ports and memory
- `DATA_W`, 32, data width
- `LOCK_MAX`, 8, max consecutive locked loader cycles before a forced core slot (≥1)

Ports:
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `c_req`  in  1  core access request; held until `c_gnt`
- `c_we`  in  1  core write (1) / read (0)
- `c_addr`  in  ADDR_W  core byte address
- `c_wdata`  in  DATA_W  core write data
- `c_gnt`  out  1  core access issued this cycle
- `c_rvalid`  out  1  core read data valid (one pulse)
- `c_rdata`  out  DATA_W  core read data
- `c_stall`  out  1  `c_req & ~c_gnt`
- `l_req`, `l_we`, `l_addr`, `l_wdata`, `l_gnt`, `l_rvalid`, `l_rdata`: loader port, same widths and meaning
- `l_lock`  in  1  loader requests exclusive ownership
- `m_we`  out  1  memory write enable
- `m_addr`  out  ADDR_W  memory address
- `m_wdata`  out  DATA_W  memory write data
- `m_rdata`  in  DATA_W  memory combinational read data

## Operation
- FSM states: ARB (round robin), LOCK (loader owns memory).
- ARB: one requester → granted. Both → grant the port not granted last (`last` register). `last` updates on every grant.
- ARB → LOCK: loader granted with `l_lock=1`.
- LOCK: loader granted whenever `l_req=1`. Core is never granted, except in the forced slot.
- LOCK → ARB: a loader grant with `l_lock=0`, or a cycle with `l_req=0`.
- Lock counter: increments on each LOCK cycle. When it reaches `LOCK_MAX` and `c_req=1`, the next cycle grants the core. The counter clears and the FSM stays in LOCK if `l_lock` is still held.
- Granted port's `we/addr/wdata` drive `m_*`. `m_we = granted & we`.
- No grant: `m_we=0`, `m_addr=c_addr`, `m_wdata=0`.
- Granted read: `m_rdata` is registered into the owner's `*_rdata`. Owner's `*_rvalid=1` in the next cycle only.
- `*_rdata` holds its last value until the next read response.
- Writes produce no `rvalid`.
- Width rules: address and data pass through unmodified. No alignment checks.

## Timing
- `*_gnt`, `c_stall`, `m_*` are combinational from requests and current state, in the same cycle.
- Write commits at the rising edge that ends the grant cycle.
- Read latency: grant in cycle N, `rvalid`/`rdata` in N+1.
- Back-to-back grants to the same or alternating ports: a grant is allowed every cycle.
- Reset (asynchronous, `rst=0`):
  - state=ARB, `last`=loader (core wins the first tie), lock counter=0
  - `c_rvalid=l_rvalid=0`, `c_rdata=l_rdata=0`
  - grants are 0 while `rst=0`
- Reset mid-operation: a pending `rvalid` is dropped. No response is produced after release.
- Requester deasserting `req` before grant is legal: no access, no state change.

## Configuration
- `DMEM_ARB_LOCK_EN` defined: LOCK state, `l_lock` and the lock counter are present as above.
- Not defined:
  - `l_lock` is ignored
  - FSM is permanently ARB (plain round robin)
  - `LOCK_MAX` unused

## Test plan
- Reset: `rst=0` with both requesting → all grants 0, rvalids 0, rdatas 0. Release → first tie grants core.
- Contention: both read continuously, core addr 0x10, loader addr 0x20 → grants alternate C,L,C,L. Each `rvalid` arrives one cycle after its grant with the matching `m_rdata`.
- Write then read: loader writes 0xDEADBEEF to 0x40, core then reads 0x40 → core `rdata=0xDEADBEEF` on the cycle after its grant. No `l_rvalid` for the write.
- Lock (`DMEM_ARB_LOCK_EN`, `LOCK_MAX=8`): loader locks for 20 cycles while core requests → core granted exactly once after each 8 loader cycles. `c_stall=1` otherwise. Returns to ARB when `l_lock` drops.
- Lock disabled build: same stimulus → strict alternation, `l_lock` has no effect.
- Async reset mid-read: assert `rst=0` between grant and response → `rvalid` never asserts. FSM returns to ARB.
